// File: rtl/bnn_pkg.sv
// Shared types and helpers for the sequential binarized fully-connected layer.
package bnn_pkg;

    typedef enum logic [1:0] {
        SIGN_GE   = 2'b00,
        SIGN_LT   = 2'b01,
        SIGN_ZERO = 2'b10,
        SIGN_ONE  = 2'b11
    } sign_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CMP,
        ST_OUT
    } state_e;

    function automatic int unsigned acc_width(input int unsigned bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR of one input chunk against one neuron's weight chunk, then popcount.
module bnn_xnor_popcount #(
    parameter int unsigned CHUNK_BITS = 32,
    parameter int unsigned CNT_W      = $clog2(CHUNK_BITS + 1)
) (
    input  logic [CHUNK_BITS-1:0] a_i,
    input  logic [CHUNK_BITS-1:0] b_i,
    output logic [CNT_W-1:0]      cnt_o
);

    logic [CHUNK_BITS-1:0] match;

    always_comb begin
        match = ~(a_i ^ b_i);
        cnt_o = '0;
        for (int unsigned i = 0; i < CHUNK_BITS; i++) begin
            cnt_o = cnt_o + CNT_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_seq_layer.sv
// Time-multiplexed binarized FC layer: PAR_NEURONS neurons per group, CHUNK_BITS input bits per cycle,
// weights/thresholds/signs fetched from external 1-cycle-latency memories.
module bnn_seq_layer
    import bnn_pkg::*;
#(
    parameter int unsigned IN_BITS     = 288,
    parameter int unsigned OUT_NEURONS = 64,
    parameter int unsigned PAR_NEURONS = 8,
    parameter int unsigned CHUNK_BITS  = 32,
    parameter int unsigned THR_W       = 10,
    parameter int unsigned BINARY_OUT  = 1,
    localparam int unsigned G     = OUT_NEURONS / PAR_NEURONS,
    localparam int unsigned C     = IN_BITS / CHUNK_BITS,
    localparam int unsigned ACC_W = acc_width(IN_BITS),
    localparam int unsigned OUT_W = (BINARY_OUT != 0) ? 1 : ACC_W,
    localparam int unsigned WA_W  = (G * C > 1) ? $clog2(G * C) : 1,
    localparam int unsigned TA_W  = (G > 1) ? $clog2(G) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [IN_BITS-1:0]                in_data_i,
    output logic [WA_W-1:0]                   wgt_addr_o,
    input  logic [PAR_NEURONS*CHUNK_BITS-1:0] wgt_data_i,
    output logic [TA_W-1:0]                   thr_addr_o,
    input  logic [PAR_NEURONS*THR_W-1:0]      thr_data_i,
    input  logic [PAR_NEURONS*2-1:0]          sign_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [OUT_NEURONS*OUT_W-1:0]      out_data_o
);

    localparam int unsigned CW    = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned CNT_W = $clog2(CHUNK_BITS + 1);

    if (OUT_NEURONS % PAR_NEURONS != 0) begin : g_chk_par
        $error("OUT_NEURONS must be a multiple of PAR_NEURONS");
    end
    if (IN_BITS % CHUNK_BITS != 0) begin : g_chk_chunk
        $error("IN_BITS must be a multiple of CHUNK_BITS");
    end
    if (THR_W < ACC_W) begin : g_chk_thr
        $error("THR_W must be at least ACC_W");
    end

    state_e state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [TA_W-1:0] g_q, g_d;
    logic            rdy_q;
    logic [IN_BITS-1:0] in_q;

    // Stage 1: address issued last cycle, memory data is on the inputs now.
    logic            v1_q;
    logic [CW-1:0]   c1_q;
    logic [TA_W-1:0] g1_q;
    logic [ACC_W-1:0] acc_q  [PAR_NEURONS];
    logic [THR_W-1:0] thr_q  [PAR_NEURONS];
    logic [1:0]       sign_q [PAR_NEURONS];

    // Stage 2: group's final accumulators are registered, compare and store.
    logic            cmp_v_q;
    logic [TA_W-1:0] cmp_g_q;
    logic [OUT_W-1:0] cmp_res [PAR_NEURONS];
    logic [OUT_NEURONS*OUT_W-1:0] res_q, res_d, out_q;

    logic [CHUNK_BITS-1:0] chunk;
    logic [CNT_W-1:0]      pc [PAR_NEURONS];

    assign chunk = in_q[c1_q*CHUNK_BITS +: CHUNK_BITS];

    for (genvar p = 0; p < PAR_NEURONS; p++) begin : g_pc
        bnn_xnor_popcount #(
            .CHUNK_BITS (CHUNK_BITS),
            .CNT_W      (CNT_W)
        ) u_pc (
            .a_i   (chunk),
            .b_i   (wgt_data_i[p*CHUNK_BITS +: CHUNK_BITS]),
            .cnt_o (pc[p])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            g_q     <= g_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        g_d     = g_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            c_d     = '0;
            g_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid_i && rdy_q) state_d = ST_RUN;
                ST_RUN: begin
                    if (c_q == CW'(C - 1)) begin
                        c_d = '0;
                        if (g_q == TA_W'(G - 1)) begin
                            g_d     = '0;
                            state_d = ST_CMP;
                        end else begin
                            g_d = g_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                ST_CMP: if (cmp_v_q && cmp_g_q == TA_W'(G - 1)) state_d = ST_OUT;
                ST_OUT: if (out_ready_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < PAR_NEURONS; p++) begin
            cmp_res[p] = '0;
            if (BINARY_OUT == 0) begin
                cmp_res[p] = OUT_W'(acc_q[p]);
            end else begin
                case (sign_e'(sign_q[p]))
                    SIGN_GE:   cmp_res[p] = OUT_W'(THR_W'(acc_q[p]) >= thr_q[p]);
                    SIGN_LT:   cmp_res[p] = OUT_W'(THR_W'(acc_q[p]) < thr_q[p]);
                    SIGN_ZERO: cmp_res[p] = '0;
                    default:   cmp_res[p] = OUT_W'(1'b1);
                endcase
            end
        end
    end

    // Per-group results collect in res_q; out_q only updates when the last group lands,
    // so an aborted run never disturbs the presented output.
    always_comb begin
        res_d = res_q;
        for (int unsigned g = 0; g < G; g++) begin
            for (int unsigned p = 0; p < PAR_NEURONS; p++) begin
                if (cmp_v_q && cmp_g_q == TA_W'(g)) begin
                    res_d[(g*PAR_NEURONS + p)*OUT_W +: OUT_W] = cmp_res[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q   <= 1'b0;
            in_q    <= '0;
            v1_q    <= 1'b0;
            c1_q    <= '0;
            g1_q    <= '0;
            cmp_v_q <= 1'b0;
            cmp_g_q <= '0;
            res_q   <= '0;
            out_q   <= '0;
            for (int unsigned p = 0; p < PAR_NEURONS; p++) begin
                acc_q[p]  <= '0;
                thr_q[p]  <= '0;
                sign_q[p] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (state_q == ST_IDLE && in_valid_i && rdy_q && !clear_i) in_q <= in_data_i;
            if (clear_i) begin
                v1_q    <= 1'b0;
                cmp_v_q <= 1'b0;
            end else begin
                v1_q    <= (state_q == ST_RUN);
                c1_q    <= c_q;
                g1_q    <= g_q;
                cmp_v_q <= v1_q && (c1_q == CW'(C - 1));
                if (v1_q) begin
                    for (int unsigned p = 0; p < PAR_NEURONS; p++) begin
                        acc_q[p] <= (c1_q == '0) ? ACC_W'(pc[p]) : acc_q[p] + ACC_W'(pc[p]);
                        if (c1_q == CW'(C - 1)) begin
                            thr_q[p]  <= thr_data_i[p*THR_W +: THR_W];
                            sign_q[p] <= sign_data_i[p*2 +: 2];
                        end
                    end
                    if (c1_q == CW'(C - 1)) cmp_g_q <= g1_q;
                end
                res_q <= res_d;
                if (cmp_v_q && cmp_g_q == TA_W'(G - 1)) out_q <= res_d;
            end
        end
    end

    assign in_ready_o  = rdy_q && (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_OUT);
    assign out_data_o  = out_q;
    assign wgt_addr_o  = WA_W'(g_q * C + c_q);
    assign thr_addr_o  = g_q;

endmodule

// File: tb/tb_bnn_seq_layer.sv
// Scoreboard bench for bnn_seq_layer: binary-output and popcount-output instances share stimulus.
module tb_bnn_seq_layer;

    localparam int IB = 16, CH = 8, ON = 4, P = 2, TW = 5, G = 2, C = 2;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic rdy_b, rdy_p, ov_b, ov_p;
    logic [1:0] wa_b, wa_p;
    logic [0:0] ta_b, ta_p;
    logic [15:0] wd_b, wd_p;
    logic [9:0] td_b, td_p;
    logic [3:0] sd_b, sd_p;
    logic [3:0] od_b;
    logic [19:0] od_p;

    logic [15:0] wmem [4];
    logic [9:0]  tmem [2];
    logic [3:0]  smem [2];

    logic [3:0]  qb [$];
    logic [19:0] qp [$];
    logic [3:0]  last_b = '0;
    int n_checks = 0, n_pass = 0;
    bit rand_bp = 0;

    always #5 clk = ~clk;

    bnn_seq_layer #(.IN_BITS(IB), .OUT_NEURONS(ON), .PAR_NEURONS(P), .CHUNK_BITS(CH),
                    .THR_W(TW), .BINARY_OUT(1)) u_bin (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy_b),
        .in_data_i(in_data), .wgt_addr_o(wa_b), .wgt_data_i(wd_b), .thr_addr_o(ta_b),
        .thr_data_i(td_b), .sign_data_i(sd_b), .out_valid_o(ov_b), .out_ready_i(out_ready),
        .out_data_o(od_b));

    bnn_seq_layer #(.IN_BITS(IB), .OUT_NEURONS(ON), .PAR_NEURONS(P), .CHUNK_BITS(CH),
                    .THR_W(TW), .BINARY_OUT(0)) u_pop (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy_p),
        .in_data_i(in_data), .wgt_addr_o(wa_p), .wgt_data_i(wd_p), .thr_addr_o(ta_p),
        .thr_data_i(td_p), .sign_data_i(sd_p), .out_valid_o(ov_p), .out_ready_i(out_ready),
        .out_data_o(od_p));

    // Synchronous parameter memories, one read port per instance
    always @(posedge clk) begin
        wd_b <= wmem[wa_b];
        td_b <= tmem[ta_b];
        sd_b <= smem[ta_b];
        wd_p <= wmem[wa_p];
        td_p <= tmem[ta_p];
        sd_p <= smem[ta_p];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: per neuron, count input bits equal to the matching weight bit, then apply sign rule.
    task automatic model(input logic [15:0] d, output logic [3:0] eb, output logic [19:0] ep);
        int g, p, acc;
        logic [15:0] w;
        logic [1:0] s;
        logic [4:0] thr;
        eb = '0;
        ep = '0;
        for (int n = 0; n < ON; n++) begin
            g = n / P;
            p = n % P;
            acc = 0;
            for (int i = 0; i < IB; i++) begin
                w = wmem[g*C + i/CH];
                if (d[i] == w[p*CH + i%CH]) acc++;
            end
            s   = smem[g][p*2 +: 2];
            thr = tmem[g][p*TW +: TW];
            case (s)
                2'b00: eb[n] = (acc >= int'(thr));
                2'b01: eb[n] = (acc < int'(thr));
                2'b10: eb[n] = 1'b0;
                default: eb[n] = 1'b1;
            endcase
            ep[n*5 +: 5] = 5'(acc);
        end
    endtask

    task automatic fill(input logic [15:0] w, input logic [9:0] t, input logic [3:0] s);
        for (int i = 0; i < 4; i++) wmem[i] = w;
        for (int i = 0; i < 2; i++) begin
            tmem[i] = t;
            smem[i] = s;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] eb, input logic [19:0] ep);
        int n = 0;
        while (!rdy_b && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy_b) chk("in_ready_wait", {31'b0, rdy_b}, 32'd1);
        qb.push_back(eb);
        qp.push_back(ep);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && (qb.size() != 0 || qp.size() != 0); i++) begin
            @(posedge clk); #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        chk("drain", qb.size() + qp.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic send_model(input logic [15:0] d);
        logic [3:0] eb;
        logic [19:0] ep;
        model(d, eb, ep);
        send(d, eb, ep);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            if (ov_b) begin
                if (qb.size() == 0) chk("spurious_out_b", {31'b0, ov_b}, 32'd0);
                else begin
                    last_b = qb.pop_front();
                    chk("out_bin", {28'b0, od_b}, {28'b0, last_b});
                end
            end
            if (ov_p) begin
                if (qp.size() == 0) chk("spurious_out_p", {31'b0, ov_p}, 32'd0);
                else chk("out_pop", {12'b0, od_p}, {12'b0, qp.pop_front()});
            end
        end
    end

    initial begin
        logic [3:0] eb;
        logic [19:0] ep;
        logic [15:0] d;
        int cnt, bad;

        fill('0, '0, '0);
        #3;
        chk("rst_in_ready", {31'b0, rdy_b}, 0);
        chk("rst_out_valid", {31'b0, ov_b | ov_p}, 0);
        chk("rst_out_data", {12'b0, od_p}, 0);
        chk("rst_out_data_b", {28'b0, od_b}, 0);
        chk("rst_addr", {29'b0, wa_b, ta_b}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ready_pre_edge", {31'b0, rdy_b}, 0);
        @(posedge clk); #1;
        chk("ready_after_rst", {30'b0, rdy_b, rdy_p}, 32'd3);

        // Ones match with latency
        fill(16'hFFFF, {5'd16, 5'd16}, 4'b0000);
        send(16'hFFFF, 4'b1111, {4{5'd16}});
        cnt = 0;
        while (!ov_b && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 6);
        wait_done();

        fill(16'h0000, {5'd1, 5'd1}, 4'b0101);
        send(16'hFFFF, 4'b1111, 20'd0);
        wait_done();
        fill(16'h0000, {5'd1, 5'd1}, 4'b0000);
        send(16'hFFFF, 4'b0000, 20'd0);
        wait_done();

        // Forced signs: neurons 0,2 -> 11, neurons 1,3 -> 10
        for (int i = 0; i < 4; i++) wmem[i] = 16'($urandom);
        tmem[0] = 10'($urandom);
        tmem[1] = 10'($urandom);
        smem[0] = 4'b1011;
        smem[1] = 4'b1011;
        d = 16'($urandom);
        model(d, eb, ep);
        send(d, 4'b0101, ep);
        wait_done();

        fill(16'h0F0F, {5'd8, 5'd9}, 4'b0000);
        model(16'h00FF, eb, ep);
        send(16'h00FF, eb, {4{5'd8}});
        wait_done();

        // Backpressure
        fill(16'hA5C3, {5'd7, 5'd9}, 4'b0100);
        d = 16'h3C96;
        model(d, eb, ep);
        out_ready = 1'b0;
        send(d, eb, ep);
        cnt = 0;
        while (!ov_b && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp_valid", {31'b0, ov_b}, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_data_b", {28'b0, od_b}, {28'b0, eb});
            chk("bp_data_p", {12'b0, od_p}, {12'b0, ep});
            chk("bp_in_ready", {31'b0, rdy_b}, 0);
            in_valid = 1'b1;
            in_data  = ~d;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after", {31'b0, rdy_b}, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ov_b) bad++;
            @(posedge clk); #1;
        end
        chk("bp_second_ignored", bad, 0);
        chk("bp_drain", qb.size(), 0);

        // clear_i mid-run
        fill(16'hFFFF, {5'd16, 5'd16}, 4'b0000);
        send(16'hFFFF, 4'b1111, {4{5'd16}});
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        qb.delete();
        qp.delete();
        chk("clear_idle", {31'b0, rdy_b}, 1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov_b || ov_p || od_b !== last_b) bad++;
            @(posedge clk); #1;
        end
        chk("clear_quiet", bad, 0);
        send(16'hFFFF, 4'b1111, {4{5'd16}});
        wait_done();

        // Asynchronous reset mid-run
        fill(16'h1234, {5'd3, 5'd12}, 4'b0001);
        send_model(16'hBEEF);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {30'b0, ov_b, ov_p}, 0);
        chk("arst_ready", {30'b0, rdy_b, rdy_p}, 0);
        chk("arst_data_b", {28'b0, od_b}, 0);
        chk("arst_data_p", {12'b0, od_p}, 0);
        chk("arst_addr", {29'b0, wa_b, ta_b}, 0);
        qb.delete();
        qp.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 4; i++) wmem[i] = 16'($urandom);
            for (int i = 0; i < 2; i++) begin
                tmem[i] = {5'($urandom_range(0, 16)), 5'($urandom_range(0, 16))};
                smem[i] = 4'($urandom);
            end
            send_model(16'($urandom));
            rand_bp = 1;
            wait_done();
            rand_bp = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
